// File: rtl/mem_io_responder.sv
// Byte-wide memory and I/O responder for the core's memory bus.
// Holds the RAM and the I/O window at mem_a[17:16]==2'b11: TX FIFO toward the
// UART, RX byte port, free-running cycle counter and a sticky program-stop flag.
// Optional feature macro: MEMIO_UART_RX_EN enables the UART receive path; when
// undefined, rx_valid/rx_data are ignored, rx_pop stays 0 and 0x30000 reads 0x00.

module mem_io_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH_BITS = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
    localparam int DEPTH     = 1 << TX_DEPTH_BITS;
    localparam logic [TX_DEPTH_BITS:0] DEPTH_C   = (TX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [TX_DEPTH_BITS:0] HIGH_MARK = (TX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [7:0] ram [0:RAM_WORDS-1];
    logic [7:0] fifo_mem [0:DEPTH-1];

    logic [TX_DEPTH_BITS-1:0] wr_ptr;
    logic [TX_DEPTH_BITS-1:0] rd_ptr;
    logic [TX_DEPTH_BITS:0]   count;

    logic [31:0] cycle_cnt;
    logic [31:0] cnt_snap;

    logic                     io;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     sel_data;
    logic                     sel_cnt0;
    logic                     sel_cnt;
    logic                     push_req;
    logic [7:0]               push_byte;
    logic                     push_ok;
    logic                     tx_pop;
    logic [7:0]               rd_value;
    logic [7:0]               rx_byte;
    logic                     unused_addr;

    // Address decode; upper address bits are don't-care.
    assign io       = (mem_a[17:16] == 2'b11);
    assign ram_idx  = mem_a[RAM_ADDR_BITS-1:0];
    assign sel_data = io && (mem_a[15:0] == 16'h0000);
    assign sel_cnt0 = io && (mem_a[15:0] == 16'h0004);
    assign sel_cnt  = io && (mem_a[15:2] == 14'h0001);
    assign unused_addr = ^mem_a[31:18];

    // TX FIFO handshake: a zero data byte is a no-op, a stop write pushes a 0x00 marker.
    assign push_req  = mem_wr && ((sel_data && (mem_dout != 8'h00)) || sel_cnt0);
    assign push_byte = sel_cnt0 ? 8'h00 : mem_dout;
    assign tx_valid  = (count != '0);
    assign tx_pop    = tx_valid && tx_ready;
    assign push_ok   = push_req && ((count < DEPTH_C) || tx_pop);
    assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign io_buffer_full = (count >= HIGH_MARK);

`ifdef MEMIO_UART_RX_EN
    assign rx_byte = rx_valid ? rx_data : 8'h00;
    assign rx_pop  = !rst_in && !mem_wr && sel_data && rx_valid;
`else
    logic unused_rx;
    assign unused_rx = rx_valid ^ (^rx_data);
    assign rx_byte   = 8'h00;
    assign rx_pop    = 1'b0;
`endif

    // RAM storage is never reset; writes land at the request edge.
    always_ff @(posedge clk_in) begin
        if (!io && mem_wr) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // FIFO storage written only on an accepted push.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_byte;
        end
    end

    // Read-data mux: RAM, RX port, counter bytes or zero for unmapped I/O.
    always_comb begin
        rd_value = 8'h00;
        if (!io) begin
            rd_value = ram[ram_idx];
        end else if (sel_data) begin
            rd_value = rx_byte;
        end else if (sel_cnt) begin
            case (mem_a[1:0])
                2'd0:    rd_value = cycle_cnt[7:0];
                2'd1:    rd_value = cnt_snap[15:8];
                2'd2:    rd_value = cnt_snap[23:16];
                default: rd_value = cnt_snap[31:24];
            endcase
        end
    end

    // Registered read data; held while the core is writing.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (!mem_wr) begin
            mem_din <= rd_value;
        end
    end

    // Free-running cycle counter and the snapshot that makes a word read coherent.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt <= 32'd0;
            cnt_snap  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (!mem_wr && sel_cnt0) begin
                cnt_snap <= cycle_cnt;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !tx_pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && tx_pop) begin
                count <= count - 1'b1;
            end
            if (push_req && !push_ok) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Sticky stop flag raised by a write to the stop/counter address.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            program_stop <= 1'b0;
        end else if (mem_wr && sel_cnt0) begin
            program_stop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: scoreboards for read data and TX bytes.

module tb_mem_io_responder;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

`ifdef MEMIO_UART_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int edges;

    logic [7:0]  rd_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  ram_m [int];
    logic [7:0]  last_din;
    logic        stop_model;
    logic        ovf_model;
    logic [31:0] snap_model;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pop         (rx_pop),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    // Clock generation.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) edges <= 0;
        else        edges <= edges + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pushModel(input logic [7:0] b);
        if (tx_q.size() < 8) tx_q.push_back(b);
        else ovf_model = 1'b1;
    endtask

    // Drives one bus cycle right after a falling edge, checks pre-edge outputs,
    // updates the models and checks registered outputs at the next falling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                                 input logic rdy, input logic rv, input logic [7:0] rd);
        logic [7:0] exp;
        logic       is_io;
        mem_a = a; mem_wr = wr; mem_dout = d;
        tx_ready = rdy; rx_valid = rv; rx_data = rd;
        #1;
        is_io = (a[17:16] == 2'b11);
        checkOutput("tx_valid", tx_valid, tx_q.size() > 0);
        checkOutput("buf_full", io_buffer_full, tx_q.size() >= 7);
        checkOutput("rx_pop", rx_pop, RX_EN && !wr && is_io && a[15:0] == 16'h0 && rv);
        if (tx_q.size() > 0) begin
            checkOutput("tx_head", tx_data, tx_q[0]);
            if (rdy) exp = tx_q.pop_front();
        end
        if (!wr) begin
            exp = 8'h00;
            if (!is_io) begin
                exp = ram_m[int'(a[16:0])];
            end else if (a[15:0] == 16'h0000) begin
                exp = (RX_EN && rv) ? rd : 8'h00;
            end else if (a[15:2] == 14'h0001) begin
                if (a[1:0] == 2'd0) begin
                    snap_model = edges;
                    exp = snap_model[7:0];
                end else begin
                    exp = 8'(snap_model >> (8 * a[1:0]));
                end
            end
            last_din = exp;
        end else begin
            if (!is_io) begin
                ram_m[int'(a[16:0])] = d;
            end else if (a[15:0] == 16'h0000) begin
                if (d != 8'h00) pushModel(d);
            end else if (a[15:0] == 16'h0004) begin
                stop_model = 1'b1;
                pushModel(8'h00);
            end
        end
        rd_q.push_back(last_din);
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("mem_din", mem_din, rd_q.pop_front());
        checkOutput("program_stop", program_stop, stop_model);
        checkOutput("tx_overflow", tx_overflow, ovf_model);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(32'h0003_0008, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
    endtask

    // Asserts reset with a read in flight, checks reset values, clears the models.
    task automatic doReset();
        mem_a = 32'h0000_0010; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rst_in = 1'b1;
        #1;
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_mem_din", mem_din, 8'h00);
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_buf_full", io_buffer_full, 1'b0);
        checkOutput("rst_stop", program_stop, 1'b0);
        checkOutput("rst_ovf", tx_overflow, 1'b0);
        checkOutput("rst_rx_pop", rx_pop, 1'b0);
        tx_q.delete();
        rd_q.delete();
        last_din   = 8'h00;
        stop_model = 1'b0;
        ovf_model  = 1'b0;
        snap_model = 32'd0;
        rst_in = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        int          n_start;
        rst_in = 1'b1;
        @(negedge clk_in);
        doReset();

        // RAM write, consecutive read, address aliasing and top address.
        applyStimulus(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'hFFFC_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0001_FFFF, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0002_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0000_0010, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // TX stream "H", 0x00 (dropped), "i" with the UART always ready.
        applyStimulus(32'h0003_0000, 1'b1, 8'h48, 1'b1, 1'b0, 8'h00);
        applyStimulus(32'h0003_0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
        applyStimulus(32'h0003_0000, 1'b1, 8'h69, 1'b1, 1'b0, 8'h00);
        idle(1'b1);
        idle(1'b1);

        // Unmapped I/O write and read have no effect.
        applyStimulus(32'h0003_0008, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
        applyStimulus(32'h0003_0001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Fill the FIFO, overflow it, then push and pop together while full.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(32'h0003_0000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
        end
        applyStimulus(32'h0003_0000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Stop write raises the flag and queues a 0x00 marker.
        applyStimulus(32'h0003_0004, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // RX port reads.
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h37);
        applyStimulus(32'h0003_0000, 1'b1, 8'h00, 1'b0, 1'b1, 8'h37);

        // Reset in the middle of a queued transfer.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0003_0000, 1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 8'h00);
        end
        doReset();
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Coherent counter word read after reset.
        n_start = edges;
        word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            word[8*i +: 8] = mem_din;
        end
        checkOutput("cnt_word", word, 32'(n_start));

        // A later snapshot differs from the first and is again coherent.
        for (int i = 0; i < 5; i++) idle(1'b0);
        n_start = edges;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            word[8*i +: 8] = mem_din;
        end
        checkOutput("cnt_word2", word, 32'(n_start));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
